// File: rtl/serial_pattern_transmitter.sv
// Parallel-in/serial-out pattern transmitter with start/busy/done handshake, MSB first.
// Optional even-parity trailer bit is enabled by defining SERIAL_TX_PARITY_EN.
module serial_pattern_transmitter #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             so,
    output logic             busy,
    output logic             done
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          so_q,    so_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [SW-1:0] load_val;

    // Parity rides in the LSB slot so it leaves the line right after data bit 0.
`ifdef SERIAL_TX_PARITY_EN
    assign load_val = {data, ^data};
`else
    assign load_val = data;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            so_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed for the coming cycle so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        so_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    shreg_d = load_val;
                    cnt_d   = CNT_LOAD;
                    so_d    = load_val[SW-1];
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    so_d   = shreg_q[SW-2];
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign so   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Directed, scoreboard-based bench for serial_pattern_transmitter (8-bit main instance plus a
// 3-bit instance feeding a 110 detector). Honours SERIAL_TX_PARITY_EN like the design.
module tb_serial_pattern_transmitter;

`ifdef SERIAL_TX_PARITY_EN
    localparam int SW  = 9;
    localparam int SW3 = 4;
`else
    localparam int SW  = 8;
    localparam int SW3 = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       so, busy, done;
    logic       start3;
    logic [2:0] data3;
    logic       so3, busy3, done3;

    logic [2:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         det_count   = 0;
    logic [1:0] det_hist    = 2'b00;

    serial_pattern_transmitter #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    serial_pattern_transmitter #(.WIDTH(3), .IDLE_LEVEL(1'b0)) dut3 (
        .clk   (clk),
        .reset (reset),
        .start (start3),
        .data  (data3),
        .so    (so3),
        .busy  (busy3),
        .done  (done3)
    );

    always #5 clk = ~clk;

    // 110 detector watching the 3-bit line only while a pattern is on it
    always @(posedge clk) begin
        if (!reset || !busy3) begin
            det_hist <= 2'b00;
        end else begin
            det_hist <= {det_hist[0], so3};
            if ({det_hist, so3} == 3'b110) det_count <= det_count + 1;
        end
    end

    // Expected {so,busy,done} for each cycle after an honoured start
    task automatic pushTransfer(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b0});
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back({^d, 1'b1, 1'b0});
`endif
        exp_q.push_back(3'b001);
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] d);
        start = st;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [2:0] obs;
        logic [2:0] expv;
        obs  = {so, busy, done};
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("[TB] FAIL %s t=%0t {so,busy,done} observed=%b expected=%b", tag, $time, obs, expv);
        end
    endtask

    task automatic step(input logic st, input logic [7:0] d, input string tag);
        applyStimulus(st, d);
        checkOutput(tag);
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int base;
        reset  = 1'b0;
        start  = 1'b1;
        data   = 8'hFF;
        start3 = 1'b0;
        data3  = 3'b000;

        $display("[TB] reset with start held high");
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, "reset_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, "post_reset");

        $display("[TB] single transfer A5");
        pushTransfer(8'hA5);
        step(1'b1, 8'hA5, "single_a5");
        for (int i = 0; i < SW + 2; i++) step(1'b0, 8'h00, "single_a5");

        $display("[TB] back-to-back F0 then 0F, stray start during busy");
        pushTransfer(8'hF0);
        step(1'b1, 8'hF0, "b2b_f0");
        for (int i = 1; i <= SW; i++) step(1'b1, (i == 4) ? 8'hFF : 8'hF0, "b2b_f0");
        pushTransfer(8'h0F);
        step(1'b1, 8'h0F, "b2b_0f");
        for (int i = 0; i < SW + 2; i++) step(1'b0, 8'h00, "b2b_0f");

        $display("[TB] abort mid-transfer");
        pushTransfer(8'hC3);
        step(1'b1, 8'hC3, "abort_pre");
        step(1'b0, 8'h00, "abort_pre");
        step(1'b0, 8'h00, "abort_pre");
        exp_q.delete();
        reset = 1'b0;
        step(1'b0, 8'h00, "abort_reset");
        reset = 1'b1;
        for (int i = 0; i < SW + 3; i++) step(1'b0, 8'h00, "abort_after");

        $display("[TB] parity patterns 07 and 03");
        pushTransfer(8'h07);
        step(1'b1, 8'h07, "parity_07");
        for (int i = 0; i < SW + 1; i++) step(1'b0, 8'h00, "parity_07");
        pushTransfer(8'h03);
        step(1'b1, 8'h03, "parity_03");
        for (int i = 0; i < SW + 1; i++) step(1'b0, 8'h00, "parity_03");

        $display("[TB] loopback 110 detector");
        base   = det_count;
        start3 = 1'b1;
        data3  = 3'b110;
        for (int i = 0; i < SW3 + 2; i++) step(1'b0, 8'h00, "loop_idle_main");
        start3 = 1'b0;
        for (int i = 0; i < 2 * SW3 + 4; i++) step(1'b0, 8'h00, "loop_idle_main");
        checkCount("loop_110_pulses", det_count - base, 2);

        base   = det_count;
        start3 = 1'b1;
        data3  = 3'b111;
        for (int i = 0; i < SW3 + 2; i++) step(1'b0, 8'h00, "loop_idle_main");
        start3 = 1'b0;
        for (int i = 0; i < 2 * SW3 + 4; i++) step(1'b0, 8'h00, "loop_idle_main");
        checkCount("loop_111_pulses", det_count - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
